// File: rtl/fetch_queue_pkg.sv
// Shared constants, entry layout and PC helper for the fetch queue.
package fetch_queue_pkg;
    localparam int OBQ_SIZE     = 16;
    localparam int FQ_DEPTH_DEF = 4;
    localparam int FQ_IDX_W     = $clog2(OBQ_SIZE) + 1;

    // Entry layout as stored in the queue (MSB first), shown at the default index width.
    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         inst;
        logic [31:0]         npc;
        logic                pred_taken;
        logic [FQ_IDX_W-1:0] obq_index;
    } fq_entry_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// Entry storage plus head/tail/count pointers for the fetch queue; flush empties it.
module fq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 102,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_enq, do_deq;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[head_q];
    assign do_enq = enq & ~full & ~flush;
    assign do_deq = deq & (count_q != '0) & ~flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) tail_d = tail_q + PTR_W'(1);
            if (do_deq) head_d = head_q + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Contents are never cleared; occupancy alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (do_enq) mem_q[tail_q] <= wdata;
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC generation feeding a small queue of {pc, inst, predicted npc} toward decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int FQ_DEPTH = FQ_DEPTH_DEF,
    parameter  int IDX_W    = $clog2(OBQ_SIZE) + 1,
    localparam int CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic [31:0]      fetch_pc,
    output logic             fetch_req,
    input  logic             mem_valid,
    input  logic [31:0]      mem_inst,
    input  logic             bp_valid,
    input  logic [31:0]      bp_pc,
    input  logic             bp_taken,
    input  logic [IDX_W-1:0] bp_index,
    input  logic             rt_redirect,
    input  logic [31:0]      rt_redirect_pc,
    input  logic             deq_ready,
    output logic             deq_valid,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_inst,
    output logic [31:0]      deq_npc,
    output logic             deq_pred_taken,
    output logic [IDX_W-1:0] deq_obq_index,
    output logic [CNT_W-1:0] count_out
);
    localparam int ENT_W = 97 + IDX_W;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      npc;
    logic             taken, full, enq;
    logic [IDX_W-1:0] idx;
    logic [ENT_W-1:0] wdata, rdata;

    assign fetch_req = ~full & ~rt_redirect;
    assign enq       = fetch_req & mem_valid;
    assign npc       = bp_valid ? bp_pc : seq_pc(fetch_pc_q);
    assign taken     = bp_valid & bp_taken;
    assign idx       = bp_valid ? bp_index : '0;
    assign wdata     = {fetch_pc_q, mem_inst, npc, taken, idx};
    assign fetch_pc  = fetch_pc_q;
    assign deq_valid = (count_out != '0);
    assign {deq_pc, deq_inst, deq_npc, deq_pred_taken, deq_obq_index} = rdata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (rt_redirect)
            fetch_pc_d = rt_redirect_pc;
        else if (enq)
            fetch_pc_d = npc;
    end

    always_ff @(posedge clock) begin
        if (reset) fetch_pc_q <= '0;
        else       fetch_pc_q <= fetch_pc_d;
    end

    fq_fifo #(.DEPTH(FQ_DEPTH), .W(ENT_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (rt_redirect),
        .enq   (enq),
        .deq   (deq_ready & deq_valid),
        .wdata (wdata),
        .rdata (rdata),
        .count (count_out),
        .full  (full)
    );
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter IDX_W, default $clog2(`OBQ_SIZE)+1, width of the OBQ index.
REQ-003 SHALL have port clock  in  1  single clock, all state on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port fetch_pc  out  32  address presented to instruction memory.
REQ-006 SHALL have port fetch_req  out  1  fetch request for fetch_pc this cycle.
REQ-007 SHALL have port mem_valid  in  1  mem_inst is valid for fetch_pc this cycle.
REQ-008 SHALL have port mem_inst  in  32  instruction word at fetch_pc.
REQ-009 SHALL have port bp_valid  in  1  branch-predictor next-PC valid for fetch_pc.
REQ-010 SHALL have port bp_pc  in  32  predicted next PC.
REQ-011 SHALL have port bp_taken  in  1  prediction taken.
REQ-012 SHALL have port bp_index  in  IDX_W  OBQ index of the prediction.
REQ-013 SHALL have port rt_redirect  in  1  retire-stage misprediction flush.
REQ-014 SHALL have port rt_redirect_pc  in  32  corrected PC.
REQ-015 SHALL have port deq_ready  in  1  decode accepts head entry.
REQ-016 SHALL have port deq_valid  out  1  head entry valid.
REQ-017 SHALL have ports deq_pc/deq_inst/deq_npc  out  32 each  head entry PC, instruction, predicted next PC.
REQ-018 SHALL have ports deq_pred_taken  out  1 and deq_obq_index  out  IDX_W  head prediction info.
REQ-019 SHALL have port count_out  out  $clog2(FQ_DEPTH)+1  occupancy.

Function
REQ-020 SHALL assert fetch_req = ~full & ~rt_redirect (combinational).
REQ-021 SHALL enqueue when fetch_req & mem_valid: entry {fetch_pc, mem_inst, npc, taken, index} written at tail; tail and count updated next edge.
REQ-022 SHALL compute npc = bp_valid ? bp_pc : fetch_pc+4 (mod 2^32); taken = bp_valid & bp_taken; index = bp_valid ? bp_index : 0.
REQ-023 SHALL load fetch_pc <= npc on an enqueue; SHALL hold fetch_pc otherwise (full, or no mem_valid).
REQ-024 SHALL drive deq_* from head entry combinationally; deq_valid = (count != 0).
REQ-025 SHALL dequeue when deq_valid & deq_ready; head advances next edge.
REQ-026 SHALL allow simultaneous enqueue and dequeue when not full; count unchanged.
REQ-027 SHALL not enqueue when full even if a dequeue occurs the same cycle.
REQ-028 SHALL wrap head/tail modulo FQ_DEPTH; count ranges 0..FQ_DEPTH.
REQ-029 On rt_redirect SHALL, next edge: head=tail=count=0, fetch_pc=rt_redirect_pc; same-cycle enqueue and dequeue ignored (deq_ready has no effect).
REQ-030 rt_redirect SHALL take priority over all other events, including reset-free stall.
REQ-031 Entry storage contents SHALL not be cleared on flush; validity is defined by count only.

Reset
REQ-032 On reset SHALL set fetch_pc=0, head=tail=count=0; thus deq_valid=0, fetch_req=1 the next cycle.
REQ-033 Reset SHALL take priority over rt_redirect and any enqueue/dequeue in the same cycle.
REQ-034 Reset mid-operation SHALL discard all queued entries.

Structure
REQ-035 FQ_ENTRY_T typedef (pc, inst, npc, pred_taken, obq_index) and `FQ_DEPTH SHALL live in sys_defs.vh.
REQ-036 Storage and pointers SHALL be a single sub-module fq_fifo; PC generation in fetch_queue top.

Verification
REQ-037 Reset, mem_valid=1, bp_valid=0, deq_ready=1 for 3 cycles -> deq_pc 0,4,8 on successive cycles, deq_npc = deq_pc+4, deq_pred_taken=0.
REQ-038 fetch_pc=0x100, bp_valid=1, bp_taken=1, bp_pc=0x200, bp_index=3 -> entry npc=0x200, obq_index=3; next fetch_pc=0x200.
REQ-039 deq_ready=0, mem_valid=1 for 6 cycles (FQ_DEPTH=4) -> count 4, fetch_req=0, fetch_pc held at 0x10; deq_ready=1 one cycle -> count 3, fetch resumes.
REQ-040 Queue holds 3 entries, rt_redirect=1 with rt_redirect_pc=0x400 and deq_ready=1 -> next cycle count=0, deq_valid=0, fetch_pc=0x400.
REQ-041 Continuous enq/deq for 10 cycles -> head/tail wrap, PCs in order with no loss or duplication; fetch_pc=0xFFFFFFFC, bp_valid=0 -> next fetch_pc=0.
